imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Loads the program image into the instruction RAM over a byte stream.
//  Holds the CPU until all PROG_WORDS 16-bit words are written, then releases it.
//  Muxes the instruction RAM address between the loader write port and the CPU
//  fetch path. Sits between the host byte link, the instruction RAM and the
//  processor core.
// PARAMETERS
//  ADDR_W      4    instruction RAM word-address width (16 words)
//  PROG_WORDS  16   words loaded per image, 1..2**ADDR_W
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: begin (re)load of the image
//  rx_data      in   8       incoming image byte
//  rx_valid     in   1       rx_data valid
//  rx_ready     out  1       loader accepts a byte this cycle
//  pc           in   16      CPU byte-address program counter
//  instruction  out  16      instruction to CPU (NOP 16'h0000 while cpu_hold)
//  imem_addr    out  ADDR_W  RAM word address (write addr or pc[ADDR_W:1])
//  imem_wdata   out  16      RAM write data
//  imem_we      out  1       RAM write enable, 1 cycle per word
//  imem_rdata   in   16      RAM read data, combinational read
//  cpu_hold     out  1       CPU stall/reset request
//  load_done    out  1       image fully loaded
//  checksum     out  16      XOR of all words written in current load
// BEHAVIOUR
//  - Reset: state=IDLE, word_cnt=0, lo_byte=0, checksum=0, cpu_hold=1,
//    load_done=0, imem_we=0, rx_ready=0.
//  - States: IDLE, LOAD_LO, LOAD_HI, WRITE, RUN.
//    * IDLE    -> LOAD_LO on start.
//    * LOAD_LO rx_ready=1; on rx_valid: lo_byte<=rx_data, go to LOAD_HI.
//    * LOAD_HI rx_ready=1; on rx_valid: hi_byte<=rx_data, go to WRITE.
//    * WRITE   rx_ready=0, imem_we=1, imem_addr=word_cnt,
//      imem_wdata={hi_byte,lo_byte}, checksum^=word.
//      If word_cnt==PROG_WORDS-1 go to RUN, else word_cnt++ and go to LOAD_LO.
//    * RUN     cpu_hold=0, load_done=1.
//  - Byte order: low byte first.
//  - Byte transfer: a byte is taken only when rx_valid && rx_ready. No byte is
//    lost when rx_valid is held high across several cycles.
//  - start while in RUN: re-enters LOAD_LO. word_cnt and checksum clear.
//    cpu_hold rises and load_done falls on the next clock edge (outputs are
//    registered).
//  - start while loading (LOAD_LO, LOAD_HI or WRITE): restarts at word 0.
//    lo_byte and checksum are discarded. A write in progress in the same cycle
//    is still issued.
//  - Address mux: imem_addr = pc[ADDR_W:1] in RUN, otherwise word_cnt.
//    pc[0] is ignored. pc bits above ADDR_W wrap silently.
//  - instruction = imem_rdata in RUN, else 16'h0000. This is zero-latency
//    combinational fetch.
//  - rst asserted mid-load aborts the load: RAM contents written so far are
//    kept, and all registers return to their reset values.
//  - word_cnt never exceeds PROG_WORDS-1.
// STRUCTURE
//  - Shared package: state encoding (3-bit localparams IDLE..RUN) and
//    NOP_INSTR=16'h0000.
//  - No sub-module. The FSM, counters and mux are in one file. The RAM stays a
//    separate instance, wired via imem_*.
// TESTING
//  1. Reset, then stream 32 bytes 00,00,01,00..0F,00 with rx_valid held high
//     -> imem_we pulses 16 times with words 0x0000..0x000F. Then load_done=1,
//     cpu_hold=0, checksum=0x0000.
//  2. Gaps in rx_valid (1 of every 3 cycles) with bytes 34,12 as the only
//     nonzero word at addr 0 -> word 0x1234 at address 0, and no extra writes.
//  3. In RUN, pc=16'h0006 -> imem_addr=3 and instruction=imem_rdata.
//     pc=16'h0007 -> same address.
//  4. start pulse in RUN -> one cycle later cpu_hold=1, load_done=0,
//     instruction=0x0000, and rx_ready=1.
//  5. rst asserted after 5 words -> state IDLE, cpu_hold=1, and no imem_we
//     until the next start. start with a full reload then succeeds.
//  6. start asserted in LOAD_HI of word 7 -> the next write goes to address 0.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//   - state_t   : loader FSM state encoding (3-bit)
//   - NOP_INSTR : instruction presented to the CPU while it is held
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4
  } state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//   Bundles the host byte link and the instruction-RAM port of the loader.
//   Signals:
//     rx_data/rx_valid/rx_ready : byte stream from the host (ready/valid)
//     imem_addr/imem_wdata/imem_we/imem_rdata : instruction RAM port
//   Modports:
//     slave  : the loader (consumes bytes, drives the RAM port)
//     master : the environment (host link source + RAM)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
  parameter int ADDR_W = 4
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              imem_we;
  logic [15:0]       imem_rdata;

  modport slave (
    input  rx_data, rx_valid, imem_rdata,
    output rx_ready, imem_addr, imem_wdata, imem_we
  );

  modport master (
    output rx_data, rx_valid, imem_rdata,
    input  rx_ready, imem_addr, imem_wdata, imem_we
  );

endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Loads a PROG_WORDS x 16-bit program image into the instruction RAM from a
//   byte stream (low byte first), holding the CPU until the image is complete.
//   After loading, the RAM address follows the CPU program counter and the
//   RAM read data is forwarded combinationally as the fetched instruction.
//
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     start        : 1-cycle pulse, begin (re)load of the image
//     pc           : CPU byte-address program counter (pc[0] ignored)
//     instruction  : fetched instruction, NOP_INSTR while the CPU is held
//     cpu_hold     : CPU stall/reset request, low only when running
//     load_done    : image fully loaded
//     checksum     : XOR of all words written during the current load
//     bus (slave)  : host byte link + instruction RAM port
// ---------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int PROG_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         pc,
  output logic [15:0]         instruction,
  output logic                cpu_hold,
  output logic                load_done,
  output logic [15:0]         checksum,
  imem_boot_loader_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(PROG_WORDS - 1);

  state_t            state,    state_nxt;
  logic [ADDR_W-1:0] word_cnt, word_cnt_nxt;
  logic [7:0]        lo_byte,  lo_byte_nxt;
  logic [7:0]        hi_byte,  hi_byte_nxt;
  logic [15:0]       checksum_nxt;
  logic              rx_ready;
  logic              imem_we;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      lo_byte  <= '0;
      hi_byte  <= '0;
      checksum <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      lo_byte  <= lo_byte_nxt;
      hi_byte  <= hi_byte_nxt;
      checksum <= checksum_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    lo_byte_nxt  = lo_byte;
    hi_byte_nxt  = hi_byte;
    checksum_nxt = checksum;
    rx_ready     = 1'b0;
    imem_we      = 1'b0;

    case (state)
      IDLE: ;
      LOAD_LO: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          lo_byte_nxt = bus.rx_data;
          state_nxt   = LOAD_HI;
        end
      end
      LOAD_HI: begin
        rx_ready = 1'b1;
        if (bus.rx_valid) begin
          hi_byte_nxt = bus.rx_data;
          state_nxt   = WRITE;
        end
      end
      WRITE: begin
        imem_we      = 1'b1;
        checksum_nxt = checksum ^ {hi_byte, lo_byte};
        if (word_cnt == LAST_WORD) begin
          state_nxt = RUN;
        end else begin
          word_cnt_nxt = word_cnt + ADDR_W'(1);
          state_nxt    = LOAD_LO;
        end
      end
      RUN: ;
      default: state_nxt = IDLE;
    endcase

    // start wins over any in-flight progress; a write already decoded from
    // WRITE above is still issued this cycle, only its checksum is dropped.
    if (start) begin
      state_nxt    = LOAD_LO;
      word_cnt_nxt = '0;
      lo_byte_nxt  = '0;
      checksum_nxt = '0;
    end
  end

  // Status flags decode directly from the state register, so they change
  // on the clock edge that enters or leaves RUN.
  assign cpu_hold  = (state != RUN);
  assign load_done = (state == RUN);

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_wdata = {hi_byte, lo_byte};
  // pc is a byte address: drop bit 0, upper bits wrap within the RAM.
  assign bus.imem_addr  = (state == RUN) ? pc[ADDR_W:1] : word_cnt;
  assign instruction    = (state == RUN) ? bus.imem_rdata : NOP_INSTR;

endmodule
